// File: rtl/sel_enc_pkg.sv
// Shared widths, instruction field positions and IR stage state for the select/encode stage.
package sel_enc_pkg;

    localparam int unsigned DEF_DATA_W     = 32;
    localparam int unsigned DEF_OPCODE_W   = 5;
    localparam int unsigned DEF_REG_ADDR_W = 4;
    localparam int unsigned DEF_C_W        = DEF_DATA_W - DEF_OPCODE_W - 2 * DEF_REG_ADDR_W;

    // Field LSBs for the default layout; C occupies [DEF_C_W-1:0] and overlaps rc.
    localparam int unsigned OPCODE_LSB = DEF_DATA_W - DEF_OPCODE_W;
    localparam int unsigned RA_LSB     = OPCODE_LSB - DEF_REG_ADDR_W;
    localparam int unsigned RB_LSB     = RA_LSB - DEF_REG_ADDR_W;
    localparam int unsigned RC_LSB     = RB_LSB - DEF_REG_ADDR_W;

    typedef enum logic {
        EMPTY,
        FULL
    } stage_e;

endpackage

// File: rtl/sel_encode_stage_reg_decoder.sv
// Enabled binary-to-one-hot decoder for a register index.
module reg_decoder #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic [ADDR_W-1:0]      idx,
    input  logic                   en,
    output logic [2**ADDR_W-1:0]   onehot
);

    // One bit per register, all zero when disabled.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/sel_encode_stage.sv
// Registered IR stage with register-select encoding, C sign extension and a
// pending-load scoreboard for hazard detection.
module sel_encode_stage
    import sel_enc_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned OPCODE_W   = DEF_OPCODE_W,
    parameter int unsigned REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int unsigned C_W        = DATA_W - OPCODE_W - 2 * REG_ADDR_W
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic [DATA_W-1:0]        ir_in,
    input  logic                     ir_valid,
    output logic                     ir_ready,
    input  logic                     retire,
    input  logic                     gra,
    input  logic                     grb,
    input  logic                     grc,
    input  logic                     r_in,
    input  logic                     r_out,
    input  logic                     ba_out,
    output logic [2**REG_ADDR_W-1:0] reg_in,
    output logic [2**REG_ADDR_W-1:0] reg_out,
    output logic [OPCODE_W-1:0]      opcode,
    output logic [DATA_W-1:0]        c_sign_ext,
    output logic                     stage_valid,
    input  logic                     load_issue,
    input  logic                     wb_valid,
    input  logic [REG_ADDR_W-1:0]    wb_idx,
    output logic                     hazard,
    output logic                     sel_err
);

    localparam int unsigned NUM_REGS = 2**REG_ADDR_W;
    localparam int unsigned OP_LO    = DATA_W - OPCODE_W;
    localparam int unsigned RA_LO    = OP_LO - REG_ADDR_W;
    localparam int unsigned RB_LO    = RA_LO - REG_ADDR_W;
    localparam int unsigned RC_LO    = RB_LO - REG_ADDR_W;

    stage_e                stage_q, stage_d;
    logic [DATA_W-1:0]     ir_q, ir_d;
    logic [NUM_REGS-1:0]   busy_q, busy_d;
    logic                  sel_err_q, sel_err_d;

    logic                  accept;
    logic                  multi_sel;
    logic                  sel_en;
    logic [REG_ADDR_W-1:0] ra, rb, rc, sel_idx;
    logic [NUM_REGS-1:0]   sel_onehot;
    logic [C_W-1:0]        c_field;

    assign ra      = ir_q[RA_LO +: REG_ADDR_W];
    assign rb      = ir_q[RB_LO +: REG_ADDR_W];
    assign rc      = ir_q[RC_LO +: REG_ADDR_W];
    assign c_field = ir_q[C_W-1:0];

    assign stage_valid = (stage_q == FULL);
    assign ir_ready    = !stage_valid || retire;
    assign accept      = ir_valid && ir_ready;
    assign multi_sel   = (gra && grb) || (gra && grc) || (grb && grc);

    // IR stage next state: accept wins over retire, retire while empty is a no-op.
    always_comb begin
        stage_d = stage_q;
        ir_d    = ir_q;
        if (accept) begin
            stage_d = FULL;
            ir_d    = ir_in;
        end else if (retire && stage_valid) begin
            stage_d = EMPTY;
        end
    end

    // Scoreboard and sticky select error; the set is applied last so it wins a same-index clear.
    always_comb begin
        busy_d    = busy_q;
        sel_err_d = sel_err_q || (stage_valid && multi_sel);
        if (wb_valid) begin
            busy_d[wb_idx] = 1'b0;
        end
        if (load_issue && stage_valid) begin
            busy_d[ra] = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            stage_q   <= EMPTY;
            ir_q      <= '0;
            busy_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            stage_q   <= stage_d;
            ir_q      <= ir_d;
            busy_q    <= busy_d;
            sel_err_q <= sel_err_d;
        end
    end

    // Prioritised field select: Gra over Grb over Grc.
    always_comb begin
        sel_idx = '0;
        if (gra) begin
            sel_idx = ra;
        end else if (grb) begin
            sel_idx = rb;
        end else if (grc) begin
            sel_idx = rc;
        end
    end

    assign sel_en = stage_valid && (gra || grb || grc);

    reg_decoder #(
        .ADDR_W (REG_ADDR_W)
    ) u_reg_decoder (
        .idx    (sel_idx),
        .en     (sel_en),
        .onehot (sel_onehot)
    );

    assign reg_in     = sel_onehot & {NUM_REGS{r_in}};
    assign reg_out    = sel_onehot & {NUM_REGS{r_out || ba_out}};
    assign opcode     = ir_q[OP_LO +: OPCODE_W];
    assign c_sign_ext = {{(DATA_W - C_W){c_field[C_W-1]}}, c_field};
    assign hazard     = stage_valid && (busy_q[ra] || busy_q[rb] || busy_q[rc]);
    assign sel_err    = sel_err_q;

endmodule

// File: tb/tb_sel_encode_stage.sv
// Directed self-checking bench for sel_encode_stage.
module tb_sel_encode_stage;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] ir_in;
    logic        ir_valid, ir_ready, retire;
    logic        gra, grb, grc, r_in, r_out, ba_out;
    logic [15:0] reg_in, reg_out;
    logic [4:0]  opcode;
    logic [31:0] c_sign_ext;
    logic        stage_valid, load_issue, wb_valid;
    logic [3:0]  wb_idx;
    logic        hazard, sel_err;

    int total = 0;
    int bad   = 0;

    sel_encode_stage dut (
        .clock       (clock),
        .clear       (clear),
        .ir_in       (ir_in),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .retire      (retire),
        .gra         (gra),
        .grb         (grb),
        .grc         (grc),
        .r_in        (r_in),
        .r_out       (r_out),
        .ba_out      (ba_out),
        .reg_in      (reg_in),
        .reg_out     (reg_out),
        .opcode      (opcode),
        .c_sign_ext  (c_sign_ext),
        .stage_valid (stage_valid),
        .load_issue  (load_issue),
        .wb_valid    (wb_valid),
        .wb_idx      (wb_idx),
        .hazard      (hazard),
        .sel_err     (sel_err)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                       input logic [3:0] rb, input logic [18:0] c);
        return {op, ra, rb, c};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        ir_valid = 0; retire = 0; gra = 0; grb = 0; grc = 0;
        r_in = 0; r_out = 0; ba_out = 0; load_issue = 0; wb_valid = 0; wb_idx = '0;
    endtask

    initial begin
        idle();
        ir_in = '0;
        clear = 1;
        step();
        #1;
        chk("rst_valid", 32'(stage_valid), 32'd0);
        chk("rst_ready", 32'(ir_ready), 32'd1);
        chk("rst_opcode", 32'(opcode), 32'd0);
        chk("rst_cse", c_sign_ext, 32'd0);
        chk("rst_hazard", 32'(hazard), 32'd0);
        chk("rst_selerr", 32'(sel_err), 32'd0);
        clear = 0;
        step();

        // Decode: ra=5 rb=3 rc=2, C=0x10123
        ir_in = mk(5'h1A, 4'd5, 4'd3, 19'h10123); ir_valid = 1;
        step();
        ir_valid = 0;
        #1;
        chk("dec_valid", 32'(stage_valid), 32'd1);
        chk("dec_opcode", 32'(opcode), 32'h1A);
        chk("dec_cse", c_sign_ext, 32'h0001_0123);
        chk("dec_hazard", 32'(hazard), 32'd0);
        gra = 1; r_in = 1; #1;
        chk("gra_rin", 32'(reg_in), 32'h0020);
        chk("gra_rin_out", 32'(reg_out), 32'h0000);
        gra = 0; r_in = 0; grb = 1; ba_out = 1; #1;
        chk("grb_baout", 32'(reg_out), 32'h0008);
        chk("grb_baout_in", 32'(reg_in), 32'h0000);
        grb = 0; ba_out = 0; grc = 1; r_out = 1; #1;
        chk("grc_rout", 32'(reg_out), 32'h0004);
        grc = 0; r_in = 1; #1;
        chk("nosel_rin", 32'(reg_in), 32'h0000);
        r_in = 0; r_out = 0;

        // Handshake: FULL, no retire -> not ready, IR unchanged
        ir_in = mk(5'h03, 4'd0, 4'd0, 19'h40000); ir_valid = 1; #1;
        chk("full_notready", 32'(ir_ready), 32'd0);
        step();
        chk("ir_held", 32'(opcode), 32'h1A);
        retire = 1; #1;
        chk("retire_ready", 32'(ir_ready), 32'd1);
        step();
        chk("swap_valid", 32'(stage_valid), 32'd1);
        chk("swap_opcode", 32'(opcode), 32'h03);
        chk("cse_neg", c_sign_ext, 32'hFFFC_0000);
        ir_in = mk(5'h1F, 4'd1, 4'd2, 19'h3FFFF);
        step();
        retire = 0; ir_valid = 0;
        chk("cse_pos", c_sign_ext, 32'h0003_FFFF);
        chk("opcode_1f", 32'(opcode), 32'h1F);

        // Multi-select: ra=1 wins, sel_err sticky
        gra = 1; grc = 1; r_out = 1; #1;
        chk("multi_out", 32'(reg_out), 32'h0002);
        chk("selerr_pre", 32'(sel_err), 32'd0);
        step();
        chk("selerr_set", 32'(sel_err), 32'd1);
        gra = 0; grc = 0; r_out = 0;
        step();
        chk("selerr_sticky", 32'(sel_err), 32'd1);

        // Retire alone empties; retire while empty ignored
        retire = 1;
        step();
        chk("retire_empty", 32'(stage_valid), 32'd0);
        chk("empty_opcode", 32'(opcode), 32'h1F);
        step();
        retire = 0;
        chk("retire_idle", 32'(stage_valid), 32'd0);
        gra = 1; r_in = 1; r_out = 1; #1;
        chk("empty_regin", 32'(reg_in), 32'h0000);
        chk("empty_regout", 32'(reg_out), 32'h0000);
        gra = 0; r_in = 0; r_out = 0;
        // load_issue while EMPTY must not mark ra=1
        load_issue = 1;
        step();
        load_issue = 0;

        // Reset mid-FULL with busy[4]
        ir_in = mk(5'h00, 4'd4, 4'd1, 19'h0); ir_valid = 1;
        step();
        ir_valid = 0;
        chk("empty_load_ignored", 32'(hazard), 32'd0);
        load_issue = 1;
        step();
        load_issue = 0;
        chk("busy4_hazard", 32'(hazard), 32'd1);
        #2 clear = 1; #1;
        chk("clr_valid", 32'(stage_valid), 32'd0);
        chk("clr_ready", 32'(ir_ready), 32'd1);
        chk("clr_hazard", 32'(hazard), 32'd0);
        chk("clr_selerr", 32'(sel_err), 32'd0);
        chk("clr_opcode", 32'(opcode), 32'd0);
        gra = 1; r_in = 1; r_out = 1; #1;
        chk("clr_regin", 32'(reg_in), 32'h0000);
        chk("clr_regout", 32'(reg_out), 32'h0000);
        gra = 0; r_in = 0; r_out = 0;
        step();
        clear = 0;
        ir_in = mk(5'h00, 4'd4, 4'd1, 19'h0); ir_valid = 1;
        step();
        ir_valid = 0;
        chk("busy_cleared", 32'(hazard), 32'd0);

        // Scoreboard: load to ra=7, then rb=7 instruction sees the hazard
        retire = 1; ir_valid = 1; ir_in = mk(5'h01, 4'd7, 4'd0, 19'h0);
        step();
        retire = 0; ir_valid = 0;
        load_issue = 1;
        step();
        load_issue = 0;
        retire = 1; ir_valid = 1; ir_in = mk(5'h02, 4'd1, 4'd7, 19'h08000);
        step();
        retire = 0; ir_valid = 0;
        chk("rb7_hazard", 32'(hazard), 32'd1);
        wb_valid = 1; wb_idx = 4'd7; #1;
        chk("wb_same_cycle", 32'(hazard), 32'd1);
        step();
        wb_valid = 0;
        chk("wb_cleared", 32'(hazard), 32'd0);

        // Same-cycle set and clear of index 4: set wins
        retire = 1; ir_valid = 1; ir_in = mk(5'h03, 4'd4, 4'd0, 19'h0);
        step();
        retire = 0; ir_valid = 0;
        load_issue = 1; wb_valid = 1; wb_idx = 4'd4;
        step();
        load_issue = 0; wb_valid = 0;
        chk("set_wins", 32'(hazard), 32'd1);
        // rc path: ra=5 rb=6 rc=4
        retire = 1; ir_valid = 1; ir_in = mk(5'h04, 4'd5, 4'd6, 19'h20000);
        step();
        retire = 0; ir_valid = 0;
        chk("rc4_hazard", 32'(hazard), 32'd1);
        wb_valid = 1; wb_idx = 4'd4;
        step();
        wb_valid = 0;
        chk("rc4_cleared", 32'(hazard), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
